// File: rtl/tick_to_level_if.sv
// Request/response bundle for the tick-to-level pulse stretcher.
interface tick_to_level_if #(
  parameter int CNT_W = 16
);
  logic             tick;
  logic [CNT_W-1:0] len;
  logic             retrig;
  logic             level;
  logic             busy;
  logic             dropped;

  modport master (
    output tick, len, retrig,
    input  level, busy, dropped
  );

  modport slave (
    input  tick, len, retrig,
    output level, busy, dropped
  );
endinterface

// File: rtl/tick_to_level.sv
// Stretches a single-cycle tick into a level of programmable length, followed by
// an optional forced-low holdoff window. Ignored ticks are flagged on dropped.
//
// state | meaning
// IDLE  | waiting for a tick; level low, not busy
// HIGH  | output pulse active; cnt holds remaining high cycles minus one
// GAP   | holdoff after a pulse; level low, busy, ticks ignored
module tick_to_level #(
  parameter int CNT_W   = 16,
  parameter int HOLDOFF = 4
) (
  input  logic        CLK,
  input  logic        reset,
  tick_to_level_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam int               GAP_N    = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [CNT_W-1:0] GAP_LOAD = GAP_N[CNT_W-1:0];

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             drop_n;
  logic             level_q, busy_q, dropped_q;
  logic             len_ok;

  assign len_ok = (bus.len != '0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      level_q   <= (state_n == HIGH);
      busy_q    <= (state_n != IDLE);
      dropped_q <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    drop_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tick) begin
          if (len_ok) begin
            state_n = HIGH;
            cnt_n   = bus.len - CNT_W'(1);
          end else begin
            drop_n = 1'b1;
          end
        end
      end
      HIGH: begin
        // An accepted retrigger wins over the terminal count, so a tick in the
        // last high cycle still extends the pulse.
        if (bus.tick && bus.retrig && len_ok) begin
          cnt_n = bus.len - CNT_W'(1);
        end else begin
          drop_n = bus.tick;
          if (cnt == '0) begin
            if (HOLDOFF > 0) begin
              state_n = GAP;
              cnt_n   = GAP_LOAD;
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end
      GAP: begin
        drop_n = bus.tick;
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.level   = level_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule
